// File: rtl/tetris_vga_renderer.sv
// Tetris playfield renderer for the DE2 VGA DAC.
// Generates 640x480@60 timing from the 50 MHz clock (one pixel every other
// clock), snapshots the 24 playfield rows once per frame during vertical
// blanking, and paints playfield cells, a white border and a gray background.
module tetris_vga_renderer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CELL_PX   = 20,
  parameter int FIELD_X0  = 220,
  parameter bit GRID      = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [29:0] row_0_export,
  input  logic [29:0] row_1_export,
  input  logic [29:0] row_2_export,
  input  logic [29:0] row_3_export,
  input  logic [29:0] row_4_export,
  input  logic [29:0] row_5_export,
  input  logic [29:0] row_6_export,
  input  logic [29:0] row_7_export,
  input  logic [29:0] row_8_export,
  input  logic [29:0] row_9_export,
  input  logic [29:0] row_10_export,
  input  logic [29:0] row_11_export,
  input  logic [29:0] row_12_export,
  input  logic [29:0] row_13_export,
  input  logic [29:0] row_14_export,
  input  logic [29:0] row_15_export,
  input  logic [29:0] row_16_export,
  input  logic [29:0] row_17_export,
  input  logic [29:0] row_18_export,
  input  logic [29:0] row_19_export,
  input  logic [29:0] row_20_export,
  input  logic [29:0] row_21_export,
  input  logic [29:0] row_22_export,
  input  logic [29:0] row_23_export,
  output logic        vga_clk,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_start
);

  localparam int ROWS    = 24;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int OW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS     = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS     = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SNAP    = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] VS_FIRST  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [HW-1:0] X_PRE     = HW'(FIELD_X0 - 1);
  localparam logic [HW-1:0] X_FIELD0  = HW'(FIELD_X0);
  localparam logic [HW-1:0] X_FEND    = HW'(FIELD_X0 + 10 * CELL_PX - 1);
  localparam logic [HW-1:0] X_BL0     = HW'(FIELD_X0 - 2);
  localparam logic [HW-1:0] X_BR0     = HW'(FIELD_X0 + 10 * CELL_PX);
  localparam logic [HW-1:0] X_BR1     = HW'(FIELD_X0 + 10 * CELL_PX + 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(CELL_PX - 1);

  localparam logic [23:0] RGB_WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_GRAY  = 24'h40_40_40;

  typedef enum logic [2:0] {
    CODE_BLACK  = 3'd0,
    CODE_CYAN   = 3'd1,
    CODE_BLUE   = 3'd2,
    CODE_ORANGE = 3'd3,
    CODE_YELLOW = 3'd4,
    CODE_GREEN  = 3'd5,
    CODE_PURPLE = 3'd6,
    CODE_RED    = 3'd7
  } cell_code_e;

  function automatic logic [23:0] palette(cell_code_e code);
    case (code)
      CODE_CYAN:   return 24'h00_FF_FF;
      CODE_BLUE:   return 24'h00_00_FF;
      CODE_ORANGE: return 24'hFF_A5_00;
      CODE_YELLOW: return 24'hFF_FF_00;
      CODE_GREEN:  return 24'h00_FF_00;
      CODE_PURPLE: return 24'h80_00_80;
      CODE_RED:    return 24'hFF_00_00;
      default:     return 24'h00_00_00;
    endcase
  endfunction

  // Row inputs gathered into an array so the snapshot is a single copy.
  logic [29:0] row_in [ROWS];
  assign row_in[0]  = row_0_export;
  assign row_in[1]  = row_1_export;
  assign row_in[2]  = row_2_export;
  assign row_in[3]  = row_3_export;
  assign row_in[4]  = row_4_export;
  assign row_in[5]  = row_5_export;
  assign row_in[6]  = row_6_export;
  assign row_in[7]  = row_7_export;
  assign row_in[8]  = row_8_export;
  assign row_in[9]  = row_9_export;
  assign row_in[10] = row_10_export;
  assign row_in[11] = row_11_export;
  assign row_in[12] = row_12_export;
  assign row_in[13] = row_13_export;
  assign row_in[14] = row_14_export;
  assign row_in[15] = row_15_export;
  assign row_in[16] = row_16_export;
  assign row_in[17] = row_17_export;
  assign row_in[18] = row_18_export;
  assign row_in[19] = row_19_export;
  assign row_in[20] = row_20_export;
  assign row_in[21] = row_21_export;
  assign row_in[22] = row_22_export;
  assign row_in[23] = row_23_export;

  logic          pix_en_q, pix_en_d;
  logic          vga_clk_q, vga_clk_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [OW-1:0] x_off_q, x_off_d;
  logic [3:0]    col_q, col_d;
  logic [OW-1:0] y_off_q, y_off_d;
  logic [4:0]    row_q, row_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          frame_start_q, frame_start_d;
  logic [29:0]   shadow_q [ROWS];
  logic [29:0]   shadow_d [ROWS];

  logic          pix_visible;
  logic          pix_hs;
  logic          pix_vs;
  logic [23:0]   pix_rgb;
  logic [29:0]   row_bits;
  cell_code_e    code;

  // Colour, sync and blanking for the pixel the counters currently point at.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    row_bits    = '0;
    code        = CODE_BLACK;
    pix_visible = (h_q < H_VIS) && (v_q < V_VIS);
    pix_hs      = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    pix_vs      = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    pix_rgb     = RGB_GRAY;

    if (row_q < 5'd24) row_bits = shadow_q[row_q];
    case (col_q)
      4'd0:    code = cell_code_e'(row_bits[2:0]);
      4'd1:    code = cell_code_e'(row_bits[5:3]);
      4'd2:    code = cell_code_e'(row_bits[8:6]);
      4'd3:    code = cell_code_e'(row_bits[11:9]);
      4'd4:    code = cell_code_e'(row_bits[14:12]);
      4'd5:    code = cell_code_e'(row_bits[17:15]);
      4'd6:    code = cell_code_e'(row_bits[20:18]);
      4'd7:    code = cell_code_e'(row_bits[23:21]);
      4'd8:    code = cell_code_e'(row_bits[26:24]);
      4'd9:    code = cell_code_e'(row_bits[29:27]);
      default: code = CODE_BLACK;
    endcase

    if (!pix_visible) begin
      pix_rgb = '0;
    end else if (h_q == X_BL0 || h_q == X_PRE || h_q == X_BR0 || h_q == X_BR1) begin
      pix_rgb = RGB_WHITE;
    end else if (h_q >= X_FIELD0 && h_q <= X_FEND) begin
      pix_rgb = palette(code);
      // Grid lines darken the last pixel row/column of occupied cells only.
      if (GRID && code != CODE_BLACK && (x_off_q == OFF_LAST || y_off_q == OFF_LAST))
        pix_rgb = '0;
    end
  end

  // Next-state for the pixel tick, beam counters, cell sub-counters,
  // output registers and the per-frame row snapshot.
  always_comb begin
    pix_en_d      = ~pix_en_q;
    vga_clk_d     = ~pix_en_q;
    h_d           = h_q;
    v_d           = v_q;
    x_off_d       = x_off_q;
    col_d         = col_q;
    y_off_d       = y_off_q;
    row_d         = row_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    shadow_d      = shadow_q;

    if (pix_en_q) begin
      // Outputs register what the counters point at now, one tick behind them.
      hs_d      = pix_hs;
      vs_d      = pix_vs;
      blank_n_d = pix_visible;
      rgb_d     = pix_rgb;

      // Horizontal cell position restarts just before the field's first column.
      if (h_q == X_PRE) begin
        x_off_d = '0;
        col_d   = '0;
      end else if (x_off_q == OFF_LAST) begin
        x_off_d = '0;
        col_d   = col_q + 4'd1;
      end else begin
        x_off_d = x_off_q + 1'b1;
      end

      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          y_off_d = '0;
          row_d   = '0;
        end else begin
          v_d = v_q + 1'b1;
          if (y_off_q == OFF_LAST) begin
            y_off_d = '0;
            row_d   = row_q + 5'd1;
          end else begin
            y_off_d = y_off_q + 1'b1;
          end
        end
        // Counters are about to enter vertical blanking: take the snapshot.
        if (v_q == V_SNAP) begin
          frame_start_d = 1'b1;
          shadow_d      = row_in;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b1;
      h_q           <= '0;
      v_q           <= '0;
      x_off_q       <= '0;
      col_q         <= '0;
      y_off_q       <= '0;
      row_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      // NOTE: the shadow rows are ordinary flops, reset so the first frame shows an empty field.
      for (int i = 0; i < ROWS; i++) shadow_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      h_q           <= h_d;
      v_q           <= v_d;
      x_off_q       <= x_off_d;
      col_q         <= col_d;
      y_off_q       <= y_off_d;
      row_q         <= row_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      shadow_q      <= shadow_d;
    end
  end

  assign vga_clk     = vga_clk_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Bench for tetris_vga_renderer: one full-size instance (horizontal timing,
// border/background pixels) and two shrunken-timing instances (GRID off/on)
// so whole frames, snapshots and colours fit in a short run. A pixel-index
// model computes every expected output with plain division/modulo.
module tb_tetris_vga_renderer;

  localparam int NI = 3;

  // Shrunken geometry: 48-pixel lines, 55-line frames, 2-pixel cells.
  localparam int S_HV = 32, S_HF = 4, S_HS = 8, S_HB = 4;
  localparam int S_VV = 48, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_CP = 2,  S_FX = 4;

  int c_hv  [NI] = '{640, S_HV, S_HV};
  int c_hf  [NI] = '{16,  S_HF, S_HF};
  int c_hsy [NI] = '{96,  S_HS, S_HS};
  int c_hb  [NI] = '{48,  S_HB, S_HB};
  int c_vv  [NI] = '{480, S_VV, S_VV};
  int c_vf  [NI] = '{10,  S_VF, S_VF};
  int c_vsy [NI] = '{2,   S_VS, S_VS};
  int c_vb  [NI] = '{33,  S_VB, S_VB};
  int c_cp  [NI] = '{20,  S_CP, S_CP};
  int c_fx  [NI] = '{220, S_FX, S_FX};
  bit c_grid[NI] = '{1'b0, 1'b0, 1'b1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [29:0] rows [24];

  logic [NI-1:0]      vclk, hs, vs, bl, sn, fs;
  logic [NI-1:0][7:0] r, g, b;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    tetris_vga_renderer #(
      .H_VISIBLE ((gi == 0) ? 640 : S_HV),
      .H_FRONT   ((gi == 0) ? 16  : S_HF),
      .H_SYNC    ((gi == 0) ? 96  : S_HS),
      .H_BACK    ((gi == 0) ? 48  : S_HB),
      .V_VISIBLE ((gi == 0) ? 480 : S_VV),
      .V_FRONT   ((gi == 0) ? 10  : S_VF),
      .V_SYNC    ((gi == 0) ? 2   : S_VS),
      .V_BACK    ((gi == 0) ? 33  : S_VB),
      .CELL_PX   ((gi == 0) ? 20  : S_CP),
      .FIELD_X0  ((gi == 0) ? 220 : S_FX),
      .GRID      ((gi == 2) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .row_0_export  (rows[0]),
      .row_1_export  (rows[1]),
      .row_2_export  (rows[2]),
      .row_3_export  (rows[3]),
      .row_4_export  (rows[4]),
      .row_5_export  (rows[5]),
      .row_6_export  (rows[6]),
      .row_7_export  (rows[7]),
      .row_8_export  (rows[8]),
      .row_9_export  (rows[9]),
      .row_10_export (rows[10]),
      .row_11_export (rows[11]),
      .row_12_export (rows[12]),
      .row_13_export (rows[13]),
      .row_14_export (rows[14]),
      .row_15_export (rows[15]),
      .row_16_export (rows[16]),
      .row_17_export (rows[17]),
      .row_18_export (rows[18]),
      .row_19_export (rows[19]),
      .row_20_export (rows[20]),
      .row_21_export (rows[21]),
      .row_22_export (rows[22]),
      .row_23_export (rows[23]),
      .vga_clk       (vclk[gi]),
      .vga_r         (r[gi]),
      .vga_g         (g[gi]),
      .vga_b         (b[gi]),
      .vga_hs        (hs[gi]),
      .vga_vs        (vs[gi]),
      .vga_blank_n   (bl[gi]),
      .vga_sync_n    (sn[gi]),
      .frame_start   (fs[gi])
    );
  end

  int n_vec  = 0;
  int n_fail = 0;
  int clk_n  = 0;
  bit running = 1'b1;

  // ---------------- behavioural model ----------------
  bit          phase;
  int          pos   [NI];
  logic [29:0] m_sh  [NI][24];
  logic [23:0] e_rgb [NI];
  bit          e_hs  [NI], e_vs [NI], e_bl [NI], e_fs [NI];
  bit          e_vclk;

  function automatic logic [23:0] palette(int code);
    case (code)
      1:       return 24'h00FFFF;
      2:       return 24'h0000FF;
      3:       return 24'hFFA500;
      4:       return 24'hFFFF00;
      5:       return 24'h00FF00;
      6:       return 24'h800080;
      7:       return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  // Colour of visible pixel (x,y) of instance i from the current shadow.
  function automatic logic [23:0] model_rgb(int i, int x, int y);
    int fx, cp, fend, col, row, xo, yo, code;
    fx   = c_fx[i];
    cp   = c_cp[i];
    fend = fx + 10 * cp;
    if (x == fx - 2 || x == fx - 1 || x == fend || x == fend + 1) return 24'hFFFFFF;
    if (x >= fx && x < fend) begin
      col  = (x - fx) / cp;
      xo   = (x - fx) % cp;
      row  = y / cp;
      yo   = y % cp;
      code = int'((m_sh[i][row] >> (3 * col)) & 30'h7);
      if (c_grid[i] && code != 0 && (xo == cp - 1 || yo == cp - 1)) return 24'h000000;
      return palette(code);
    end
    return 24'h404040;
  endfunction

  // Model: a pixel index advances every second clock; outputs describe the
  // pixel index before the advance; the snapshot is taken when the index
  // reaches the first blanked line.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  = 1'b0;
      e_vclk = 1'b1;
      for (int i = 0; i < NI; i++) begin
        pos[i] = 0; e_rgb[i] = '0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
        e_bl[i] = 1'b0; e_fs[i] = 1'b0;
        for (int k = 0; k < 24; k++) m_sh[i][k] = '0;
      end
    end else begin
      e_vclk = !phase;
      for (int i = 0; i < NI; i++) e_fs[i] = 1'b0;
      if (phase) begin
        for (int i = 0; i < NI; i++) begin
          int ht, vt, h, v, hs0, vs0;
          ht  = c_hv[i] + c_hf[i] + c_hsy[i] + c_hb[i];
          vt  = c_vv[i] + c_vf[i] + c_vsy[i] + c_vb[i];
          h   = pos[i] % ht;
          v   = pos[i] / ht;
          hs0 = c_hv[i] + c_hf[i];
          vs0 = c_vv[i] + c_vf[i];
          e_bl[i]  = (h < c_hv[i]) && (v < c_vv[i]);
          e_hs[i]  = !(h >= hs0 && h < hs0 + c_hsy[i]);
          e_vs[i]  = !(v >= vs0 && v < vs0 + c_vsy[i]);
          e_rgb[i] = e_bl[i] ? model_rgb(i, h, v) : 24'h0;
          pos[i]   = (pos[i] + 1) % (ht * vt);
          if (pos[i] == c_vv[i] * ht) begin
            e_fs[i] = 1'b1;
            for (int k = 0; k < 24; k++) m_sh[i][k] = rows[k];
          end
        end
      end
      phase = !phase;
    end
  end

  // Clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_n = 0;
    else        clk_n = clk_n + 1;
  end

  // Every-cycle comparison of all outputs, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      for (int i = 0; i < NI; i++) begin
        logic [29:0] act, exp;
        act = {r[i], g[i], b[i], hs[i], vs[i], bl[i], fs[i], vclk[i], sn[i]};
        exp = {e_rgb[i], e_hs[i], e_vs[i], e_bl[i], e_fs[i], e_vclk, 1'b0};
        n_vec++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL outputs inst%0d t=%0t: got rgb=%h hs/vs/bl/fs/vclk/sync=%b, want rgb=%h %b",
                   i, $time, act[29:6], act[5:0], exp[29:6], exp[5:0]);
        end
      end
    end
  end

  // ---------------- checks and stimulus ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic cur(int sel);
    case (sel)
      0:       return hs[0];
      1:       return vs[1];
      default: return fs[1];
    endcase
  endfunction

  // Wait (bounded) until the selected output has the given level; returns the edge count.
  task automatic wait_level(input int sel, input logic level, input int budget,
                            input string name, output int at);
    int k;
    k = 0;
    while (cur(sel) !== level && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (cur(sel) !== level) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: level %0b not seen within %0d clk", name, level, budget);
    end
    at = clk_n;
  endtask

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int t0, t1, t2, k;
    for (int i = 0; i < 24; i++) rows[i] = '0;
    rows[0]  = 30'h0000_0007;
    rows[23] = 30'd4 << 27;
    rst_n = 1'b0;
    tick_wait(3);
    check("reset_rgb_full", longint'({r[0], g[0], b[0]}), 0);
    check("reset_flags_full", longint'({hs[0], vs[0], bl[0], fs[0], vclk[0]}), 5'b11001);
    rst_n = 1'b1;

    // Horizontal timing on the full-size instance: 656 pixels + 1 tick latency.
    wait_level(0, 1'b0, 3000, "first_hs_low", t0);
    check("first_hs_low_edge", t0, 1314);
    wait_level(0, 1'b1, 3000, "hs_rise", t1);
    check("hs_low_clks", t1 - t0, 192);
    wait_level(0, 1'b0, 3000, "hs_fall2", t2);
    check("hs_period_clks", t2 - t0, 1600);

    // First snapshot on the small instance: 48 lines * 48 pixels * 2 clk.
    wait_level(2, 1'b1, 6000, "first_frame_start", t0);
    check("first_frame_start_edge", t0, 4608);

    // Pin the model with hand-computed pixels.
    check("model_red_cell", longint'(model_rgb(1, 4, 0)), 24'hFF0000);
    check("model_red_cell_end", longint'(model_rgb(1, 5, 1)), 24'hFF0000);
    check("model_next_col_black", longint'(model_rgb(1, 6, 0)), 24'h000000);
    check("model_yellow_grid_off", longint'(model_rgb(1, 23, 47)), 24'hFFFF00);
    check("model_yellow_grid_on", longint'(model_rgb(2, 22, 46)), 24'hFFFF00);
    check("model_grid_line", longint'(model_rgb(2, 23, 46)), 24'h000000);
    check("model_border_left", longint'(model_rgb(1, 3, 10)), 24'hFFFFFF);
    check("model_border_right", longint'(model_rgb(1, 25, 10)), 24'hFFFFFF);
    check("model_full_x219", longint'(model_rgb(0, 219, 7)), 24'hFFFFFF);
    check("model_full_x421", longint'(model_rgb(0, 421, 7)), 24'hFFFFFF);
    check("model_full_bg", longint'(model_rgb(0, 0, 7)), 24'h404040);

    wait_level(2, 1'b0, 10, "fs_drop", t1);
    check("frame_start_width", t1 - t0, 1);
    wait_level(2, 1'b1, 6000, "frame_start2", t2);
    check("frame_start_period", t2 - t0, 5280);

    // Row 5 changes mid-frame (line 10): stays black this frame, red next.
    tick_wait(672 + 960);
    rows[5] = '1;
    wait_level(2, 1'b1, 6000, "frame_start3", t0);

    // Vertical sync on the small instance.
    wait_level(1, 1'b0, 6000, "vs_fall", t0);
    wait_level(1, 1'b1, 6000, "vs_rise", t1);
    check("vs_low_clks", t1 - t0, 192);
    wait_level(1, 1'b0, 6000, "vs_fall2", t2);
    check("vs_period_clks", t2 - t0, 5280);

    // Random row updates at random times across several frames.
    for (int n = 0; n < 40; n++) begin
      tick_wait($urandom_range(50, 600));
      rows[$urandom_range(0, 23)] = 30'($urandom);
    end

    // Reset in the middle of a visible line, held 3 clk.
    k = 0;
    while (pos[1] != 20 * 48 + 10 && k < 6000) begin
      @(posedge clk);
      k++;
    end
    check("reset_point_reached", longint'(pos[1]), 20 * 48 + 10);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rgb", longint'({r[1], g[1], b[1]}), 0);
    check("midreset_flags", longint'({hs[1], vs[1], bl[1], fs[1], vclk[1]}), 5'b11001);
    tick_wait(3);
    rst_n = 1'b1;
    wait_level(0, 1'b0, 3000, "hs_low_after_reset", t0);
    check("hs_low_after_reset_edge", t0, 1314);
    wait_level(2, 1'b1, 6000, "fs_after_reset", t1);
    check("fs_after_reset_edge", t1, 4608);
    tick_wait(6000);

    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
